keypad_scan_encoder: RTL and testbench
======================================

# keypad_scan_encoder

Scans a 3-column × 4-row matrix keypad, synchronises and debounces the row lines, and encodes the pressed key into a 4-bit note code. It sits directly upstream of the game controller. It drives that block's `keypad_input[3:0]` bus and its `keypad_enable` strobe, and it suppresses presses while the controller is replaying the melody.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clocks per column slot; legal minimum 4.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical scan frames required to accept a change; legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `row_in`  in  4  keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `lock`  in  1  when high, press and release pulses are suppressed (melody playing).
- `col_out`  out  3  column drive, active-low, one-hot-low.
- `key_code`  out  4  last accepted key code, 1..12.
- `key_valid`  out  1  one-clock pulse on an accepted press; feeds `keypad_enable`.
- `key_release`  out  1  one-clock pulse when the accepted key goes to none.
- `key_held`  out  1  level; high while the debounced code is non-zero.

## Operation
- **Reset values:**
  - `col_out`=3'b110, column index 0, slot counter 0.
  - Sync flops 4'b1111.
  - Frame bitmap, candidate, stable count and debounced code all 0.
  - `key_code`=0, `key_valid`=0, `key_release`=0, `key_held`=0.
- **Row synchronisation:** `row_in` passes through a 2-flop synchroniser. Only the second stage is used.
- **Scan:**
  - The slot counter counts 0..`SCAN_DIV`-1.
  - At count `SCAN_DIV`-1, the inverted synced rows are written into the 12-bit frame bitmap for the current column, and the column index advances 0→1→2→0.
  - `col_out` follows the column index: 110, 101, 011.
- **Encoding:**
  - Key (row r, column c) has code r*3+c+1. Row 0 / column 0 is code 1; row 3 / column 2 is code 12.
  - At frame end (column 2, count `SCAN_DIV`-1), `frame_code` is computed from the bitmap: 0 if no bit is set.
  - Multi-key handling is defined under Configuration.
  - The bitmap clears for the next frame.
- **Debounce (evaluated at frame end only):**
  - If `frame_code` ≠ candidate: candidate ← `frame_code`, stable count ← 1.
  - Otherwise the stable count increments, saturating at `DEBOUNCE_FRAMES`.
  - When the stable count equals `DEBOUNCE_FRAMES` and candidate ≠ debounced code, the debounced code ← candidate (the accept event).
- **Accept events:**
  - New code non-zero:
    - `key_code` ← new code.
    - `key_valid` pulses unless `lock`.
    - `key_held`=1.
  - New code 0:
    - `key_code` is held.
    - `key_release` pulses unless `lock`.
    - `key_held`=0.
  - A direct change from one non-zero code to another non-zero code is a press of the new key. It gives a `key_valid` pulse with no `key_release`.
- **Lock behaviour:**
  - `lock` is sampled in the accept cycle only.
  - Debounce and `key_held` still track the keypad while locked.
  - A key already held when `lock` falls generates no pulse; a fresh press is required.

## Timing
- `key_valid` and `key_release` are registered and assert in the clock after the frame-end edge that causes acceptance. They are high for exactly 1 clock.
- `key_code` is updated on the same edge as `key_valid` and stays stable until the next accepted press.
- Frame length: 3·`SCAN_DIV` clocks.
- Press latency from a clean, bounce-free press: between `DEBOUNCE_FRAMES` and `DEBOUNCE_FRAMES`+1 frames, plus 2 sync clocks, plus 1 clock.
- A bounce that breaks stability restarts the count; no pulse is emitted until `DEBOUNCE_FRAMES` consecutive identical frames are seen.
- `lock` has no internal synchroniser; it is produced on `clk`.
- Reset mid-frame: outputs return to their reset values immediately. Scanning restarts at column 0, count 0, and any in-progress press must re-debounce from zero.
- The counters never overflow: the slot counter wraps at `SCAN_DIV`-1, and the stable count saturates.

## Configuration
- **`KEYPAD_MULTI_REJECT_EN` defined:** a frame with two or more bitmap bits set gives `frame_code`=0, i.e. it is treated as no key (ghost/chord rejection).
- **`KEYPAD_MULTI_REJECT_EN` undefined:** the lowest set code wins. For example, codes 2 and 7 pressed together give `frame_code`=2.

## Test plan
- **Reset:** assert `reset` mid-slot → immediately `col_out`=110, `key_code`=0, `key_valid`=0, `key_held`=0. After release, column 1 is driven after `SCAN_DIV` clocks.
- **Clean press:** `SCAN_DIV`=4, `DEBOUNCE_FRAMES`=2; hold row 1 low while column 2 is driven (code 6) for 3 frames → exactly one `key_valid` pulse with `key_code`=6 and `key_held`=1. On release, one `key_release` pulse follows 2–3 frames later, with `key_code` still 6.
- **Bounce:** toggle code-6 contact on alternate frames for 6 frames, then hold → no pulse during the toggling. A single `key_valid` pulse follows `DEBOUNCE_FRAMES` stable frames after toggling stops.
- **Lock:** press code 3 with `lock`=1, then drop `lock` while the key is still held → no `key_valid`, `key_held`=1. Release and re-press code 3 → one `key_valid` pulse.
- **Chord:** hold codes 2 and 7 together → with `KEYPAD_MULTI_REJECT_EN`, no pulse and `key_held`=0. Without it, one `key_valid` pulse with `key_code`=2.
- **Key change:** hold code 1, then switch to code 12 with no gap → one `key_valid` pulse per key, with no intervening `key_release`.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// ---------------------------------------------------------------------------
// keypad_scan_encoder
//
// Scans a 3-column x 4-row matrix keypad, synchronises and debounces the row
// lines, and encodes the pressed key into a 4-bit note code for the game
// controller (drives its keypad_input[3:0] bus and keypad_enable strobe).
//
// Parameters:
//   SCAN_DIV         clocks per column slot (minimum 4)
//   DEBOUNCE_FRAMES  identical consecutive frames needed to accept (1..15)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   row_in[3:0]  in   keypad rows, active-low, asynchronous to clk
//   lock         in   suppresses press/release pulses (melody replay)
//   col_out[2:0] out  column drive, active-low one-hot
//   key_code     out  last accepted key code (1..12)
//   key_valid    out  one-clock pulse on an accepted press
//   key_release  out  one-clock pulse when the accepted key goes to none
//   key_held     out  high while the debounced code is non-zero
//
// Build option:
//   KEYPAD_MULTI_REJECT_EN  when defined, a frame with two or more keys down
//                           encodes as "no key"; otherwise the lowest code wins.
//
// Key (row r, column c) encodes as r*3 + c + 1; frame bitmap bit r*3 + c.
// ---------------------------------------------------------------------------
module keypad_scan_encoder #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    input  logic       lock,
    output logic [2:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held
);

    localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       DEB_MAX   = 4'(DEBOUNCE_FRAMES);

    // Encode one scan frame into a key code (0 = no key).
    function automatic logic [3:0] encode_frame(input logic [11:0] bm);
        logic [3:0] code;
`ifdef KEYPAD_MULTI_REJECT_EN
        logic [3:0] nbits;
        code  = 4'd0;
        nbits = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (bm[i]) begin
                code  = 4'(i + 1);
                nbits = nbits + 4'd1;
            end
        end
        // Chords and ghost patterns are treated as no key at all.
        if (nbits != 4'd1) begin
            code = 4'd0;
        end
`else
        code = 4'd0;
        // Scanning downwards leaves the lowest set code as the result.
        for (int i = 11; i >= 0; i--) begin
            if (bm[i]) begin
                code = 4'(i + 1);
            end
        end
`endif
        return code;
    endfunction

    // State registers
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [2:0]       col_out_q, col_out_d;
    logic [11:0]      bitmap_q, bitmap_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_release_q, key_release_d;
    logic             key_held_q, key_held_d;

    // Combinational helpers
    logic             slot_end;
    logic             frame_end;
    logic [11:0]      bitmap_cap;
    logic [3:0]       frame_code;
    logic             accept;

    // ---- Stage: row synchroniser -------------------------------------------
    always_comb begin
        sync1_d = row_in;
        sync2_d = sync1_q;
    end

    // ---- Stage: column scan and frame capture ------------------------------
    always_comb begin
        slot_end  = (slot_cnt_q == SLOT_LAST);
        frame_end = slot_end && (col_idx_q == 2'd2);

        slot_cnt_d = slot_end ? '0 : (slot_cnt_q + CNT_ONE);

        col_idx_d = col_idx_q;
        if (slot_end) begin
            col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : (col_idx_q + 2'd1);
        end

        case (col_idx_d)
            2'd0:    col_out_d = 3'b110;
            2'd1:    col_out_d = 3'b101;
            default: col_out_d = 3'b011;
        endcase

        // Rows are active-low; a pressed key in the driven column sets its bit.
        bitmap_cap = bitmap_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (slot_end && (col_idx_q == 2'(c))) begin
                    bitmap_cap[r*3 + c] = ~sync2_q[r];
                end
            end
        end

        // The frame code includes the column captured on this very edge.
        frame_code = encode_frame(bitmap_cap);
        bitmap_d   = frame_end ? 12'd0 : bitmap_cap;
    end

    // ---- Stage: debounce and output event generation -----------------------
    always_comb begin
        cand_d        = cand_q;
        stable_d      = stable_q;
        deb_d         = deb_q;
        accept        = 1'b0;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;

        if (frame_end) begin
            if (frame_code != cand_q) begin
                cand_d   = frame_code;
                stable_d = 4'd1;
            end else if (stable_q < DEB_MAX) begin
                stable_d = stable_q + 4'd1;
            end

            if ((stable_d == DEB_MAX) && (cand_d != deb_q)) begin
                accept = 1'b1;
                deb_d  = cand_d;
            end
        end

        // lock only gates the pulses; the debounced state keeps tracking so a
        // key held across the end of lock needs a fresh press.
        if (accept) begin
            if (cand_d != 4'd0) begin
                key_code_d  = cand_d;
                key_valid_d = ~lock;
            end else begin
                key_release_d = ~lock;
            end
        end

        key_held_d = (deb_d != 4'd0);
    end

    // ---- Stage: registers ---------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 4'b1111;
            sync2_q       <= 4'b1111;
            slot_cnt_q    <= '0;
            col_idx_q     <= 2'd0;
            col_out_q     <= 3'b110;
            bitmap_q      <= 12'd0;
            cand_q        <= 4'd0;
            stable_q      <= 4'd0;
            deb_q         <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            slot_cnt_q    <= slot_cnt_d;
            col_idx_q     <= col_idx_d;
            col_out_q     <= col_out_d;
            bitmap_q      <= bitmap_d;
            cand_q        <= cand_d;
            stable_q      <= stable_d;
            deb_q         <= deb_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_held_q    <= key_held_d;
        end
    end

    assign col_out     = col_out_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_held    = key_held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_encoder
//
// Directed bench for keypad_scan_encoder with SCAN_DIV=4, DEBOUNCE_FRAMES=2
// (frame = 12 clocks). A small keypad model pulls a row low whenever a
// pressed key sits in the currently driven column.
// ---------------------------------------------------------------------------
module tb_keypad_scan_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int FRAME    = 3 * SCAN_DIV;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic       lock;
    logic [2:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_held;

    logic [11:0] pressed;   // bit r*3+c = key (row r, column c) held down

    int total_cnt;
    int fail_cnt;
    int valid_cnt;
    int release_cnt;
    logic [3:0] valid_code;
    int vb;
    int rb;

    keypad_scan_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_in     (row_in),
        .lock       (lock),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if ((pressed[r*3 +: 3] & ~col_out) != 3'b000) begin
                row_in[r] = 1'b0;
            end
        end
    end

    // Pulse monitor: one count per clock a pulse is high.
    always @(negedge clk) begin
        if (key_valid) begin
            valid_cnt  = valid_cnt + 1;
            valid_code = key_code;
        end
        if (key_release) begin
            release_cnt = release_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [11:0] k);
        @(negedge clk);
        pressed = k;
    endtask

    task automatic set_lock(input logic l);
        @(negedge clk);
        lock = l;
    endtask

    initial begin
        total_cnt   = 0;
        fail_cnt    = 0;
        valid_cnt   = 0;
        release_cnt = 0;
        valid_code  = 4'd0;
        pressed     = 12'd0;
        lock        = 1'b0;
        reset       = 1'b1;

        // ---- Reset values and column sequence ----
        clks(2);
        check("rst_col",     32'(col_out),     32'(3'b110));
        check("rst_code",    32'(key_code),    32'd0);
        check("rst_valid",   32'(key_valid),   32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        check("rst_held",    32'(key_held),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        clks(3);
        check("col0_hold", 32'(col_out), 32'(3'b110));
        clks(1);
        check("col1", 32'(col_out), 32'(3'b101));
        clks(4);
        check("col2", 32'(col_out), 32'(3'b011));
        clks(4);
        check("col_wrap", 32'(col_out), 32'(3'b110));

        // ---- Clean press of code 6 (row 1, column 2) ----
        vb = valid_cnt; rb = release_cnt;
        set_keys(12'd1 << 5);
        clks(FRAME - 1);
        check("press6_early", 32'(valid_cnt - vb), 32'd0);
        clks(3 * FRAME + 1);
        check("press6_valid",   32'(valid_cnt - vb),   32'd1);
        check("press6_vcode",   32'(valid_code),       32'd6);
        check("press6_code",    32'(key_code),         32'd6);
        check("press6_held",    32'(key_held),         32'd1);
        check("press6_norel",   32'(release_cnt - rb), 32'd0);
        vb = valid_cnt;
        set_keys(12'd0);
        clks(4 * FRAME);
        check("rel6_release", 32'(release_cnt - rb), 32'd1);
        check("rel6_code",    32'(key_code),         32'd6);
        check("rel6_held",    32'(key_held),         32'd0);
        check("rel6_novalid", 32'(valid_cnt - vb),   32'd0);

        // ---- Bounce: alternate frames, then hold ----
        vb = valid_cnt; rb = release_cnt;
        for (int i = 0; i < 6; i++) begin
            set_keys((i % 2 == 0) ? (12'd1 << 5) : 12'd0);
            clks(FRAME - 1);
        end
        check("bounce_novalid", 32'(valid_cnt - vb),   32'd0);
        check("bounce_norel",   32'(release_cnt - rb), 32'd0);
        set_keys(12'd1 << 5);
        clks(FRAME - 1);
        check("bounce_hold_early", 32'(valid_cnt - vb), 32'd0);
        clks(3 * FRAME + 1);
        check("bounce_hold_valid", 32'(valid_cnt - vb), 32'd1);
        check("bounce_hold_code",  32'(valid_code),     32'd6);

        // ---- Reset mid-frame while a key is held ----
        for (int k = 0; k < 2 * FRAME && col_out != 3'b101; k++) begin
            @(posedge clk);
        end
        #1;
        check("mid_pre_col",  32'(col_out),  32'(3'b101));
        check("mid_pre_held", 32'(key_held), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_col",   32'(col_out),   32'(3'b110));
        check("mid_code",  32'(key_code),  32'd0);
        check("mid_valid", 32'(key_valid), 32'd0);
        check("mid_held",  32'(key_held),  32'd0);
        clks(2);
        @(negedge clk);
        reset = 1'b0;
        vb = valid_cnt;
        clks(FRAME - 1);
        check("mid_redeb_early", 32'(valid_cnt - vb), 32'd0);
        clks(3 * FRAME + 1);
        check("mid_redeb_valid", 32'(valid_cnt - vb), 32'd1);
        check("mid_redeb_code",  32'(key_code),       32'd6);
        set_keys(12'd0);
        clks(4 * FRAME);

        // ---- Lock: press code 3 while locked ----
        vb = valid_cnt; rb = release_cnt;
        set_lock(1'b1);
        set_keys(12'd1 << 2);
        clks(4 * FRAME);
        check("lock_novalid", 32'(valid_cnt - vb), 32'd0);
        check("lock_held",    32'(key_held),       32'd1);
        set_lock(1'b0);
        clks(4 * FRAME);
        check("unlock_novalid", 32'(valid_cnt - vb), 32'd0);
        check("unlock_held",    32'(key_held),       32'd1);
        set_keys(12'd0);
        clks(4 * FRAME);
        check("lock_rel_release", 32'(release_cnt - rb), 32'd1);
        check("lock_rel_held",    32'(key_held),         32'd0);
        set_keys(12'd1 << 2);
        clks(4 * FRAME);
        check("repress3_valid", 32'(valid_cnt - vb), 32'd1);
        check("repress3_code",  32'(valid_code),     32'd3);
        rb = release_cnt;
        set_lock(1'b1);
        set_keys(12'd0);
        clks(4 * FRAME);
        check("lock_norel", 32'(release_cnt - rb), 32'd0);
        check("lock_rel_held0", 32'(key_held),     32'd0);
        set_lock(1'b0);

        // ---- Chord: codes 2 and 7 together ----
        vb = valid_cnt;
        set_keys((12'd1 << 1) | (12'd1 << 6));
        clks(4 * FRAME);
`ifdef KEYPAD_MULTI_REJECT_EN
        check("chord_novalid", 32'(valid_cnt - vb), 32'd0);
        check("chord_held",    32'(key_held),       32'd0);
`else
        check("chord_valid", 32'(valid_cnt - vb), 32'd1);
        check("chord_code",  32'(key_code),       32'd2);
        check("chord_held",  32'(key_held),       32'd1);
`endif
        set_keys(12'd0);
        clks(4 * FRAME);

        // ---- Key change: code 1 directly to code 12 ----
        vb = valid_cnt; rb = release_cnt;
        set_keys(12'd1 << 0);
        clks(4 * FRAME);
        check("chg1_valid", 32'(valid_cnt - vb), 32'd1);
        check("chg1_code",  32'(key_code),       32'd1);
        set_keys(12'd1 << 11);
        clks(4 * FRAME);
        check("chg12_valid", 32'(valid_cnt - vb),   32'd2);
        check("chg12_code",  32'(key_code),         32'd12);
        check("chg12_norel", 32'(release_cnt - rb), 32'd0);
        set_keys(12'd0);
        clks(4 * FRAME);
        check("chg_rel_release", 32'(release_cnt - rb), 32'd1);
        check("chg_rel_code",    32'(key_code),         32'd12);

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
